// File: rtl/reorder_rd_ctrl.sv
// Reads a filled re-order buffer in digit-reversed address order and streams it out valid/ready.
// Latency: wr_done -> first rd_en +1 cycle, first out_valid +3 cycles; one beat per cycle sustained.
// Backpressure: reads pause while 2 words are held or in flight; the head word holds while out_ready is low.
module reorder_rd_ctrl #(
  parameter int AW    = 11,
  parameter int DW    = 32,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          frame_done,
  output logic          busy,
  output logic          ovr_err
);

  localparam int ND = AW / DIGIT;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            inflight_q;
  logic            inflight_last_q;
  logic            frame_done_q, frame_done_d;
  logic            ovr_err_q, ovr_err_d;

  // Two-entry skid buffer, head entry is what the output presents.
  logic [1:0]      skid_cnt_q, skid_cnt_d;
  logic [DW-1:0]   head_dat_q, head_dat_d;
  logic            head_last_q, head_last_d;
  logic [DW-1:0]   tail_dat_q, tail_dat_d;
  logic            tail_last_q, tail_last_d;

  logic            pop;
  logic            push;
  logic            cnt_is_max;
  logic [2:0]      occ;

  assign pop        = out_valid & out_ready;
  assign push       = inflight_q;
  assign cnt_is_max = &cnt_q;
  // Words that will be held after this cycle if no new read is issued.
  assign occ        = {1'b0, skid_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Digit reversal is a pure rewire of the counter: digit g moves to digit ND-1-g.
  for (genvar g = 0; g < ND; g++) begin : g_rev
    assign rd_addr[(ND-1-g)*DIGIT +: DIGIT] = cnt_q[g*DIGIT +: DIGIT];
  end

  assign out_valid  = (skid_cnt_q != 2'd0);
  assign out_data   = head_dat_q;
  assign out_last   = head_last_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;
  assign ovr_err    = ovr_err_q;

  // Next-state, read strobe and completion decode for the frame FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_en        = 1'b0;
    frame_done_d = 1'b0;
    ovr_err_d    = ovr_err_q | (wr_done & (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (wr_done) begin
          state_d = S_READ;
          cnt_d   = '0;
        end
      end
      S_READ: begin
        rd_en = (occ < 3'd2);
        if (rd_en) begin
          cnt_d = cnt_q + AW'(1);
          if (cnt_is_max) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && out_last) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state, read counter, in-flight tracking and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      frame_done_q    <= 1'b0;
      ovr_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en & cnt_is_max;
      frame_done_q    <= frame_done_d;
      ovr_err_q       <= ovr_err_d;
    end
  end

  // Skid buffer update: push the returning RAM word, pop on accepted beat, both at once allowed.
  always_comb begin
    skid_cnt_d  = skid_cnt_q;
    head_dat_d  = head_dat_q;
    head_last_d = head_last_q;
    tail_dat_d  = tail_dat_q;
    tail_last_d = tail_last_q;
    if (push && pop) begin
      if (skid_cnt_q == 2'd2) begin
        head_dat_d  = tail_dat_q;
        head_last_d = tail_last_q;
        tail_dat_d  = rd_data;
        tail_last_d = inflight_last_q;
      end else begin
        head_dat_d  = rd_data;
        head_last_d = inflight_last_q;
      end
    end else if (push) begin
      if (skid_cnt_q == 2'd0) begin
        head_dat_d  = rd_data;
        head_last_d = inflight_last_q;
      end else begin
        tail_dat_d  = rd_data;
        tail_last_d = inflight_last_q;
      end
      skid_cnt_d = skid_cnt_q + 2'd1;
    end else if (pop) begin
      head_dat_d  = tail_dat_q;
      head_last_d = tail_last_q;
      skid_cnt_d  = skid_cnt_q - 2'd1;
    end
  end

  // Skid buffer storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_cnt_q  <= 2'd0;
      head_dat_q  <= '0;
      head_last_q <= 1'b0;
      tail_dat_q  <= '0;
      tail_last_q <= 1'b0;
    end else begin
      skid_cnt_q  <= skid_cnt_d;
      head_dat_q  <= head_dat_d;
      head_last_q <= head_last_d;
      tail_dat_q  <= tail_dat_d;
      tail_last_q <= tail_last_d;
    end
  end

endmodule

// File: tb/tb_reorder_rd_ctrl.sv
// Testbench for reorder_rd_ctrl: bit-reverse instance (AW=3) and radix-16 instance (AW=12, DIGIT=4).
// Each instance has a RAM model and a frame-level reference model checked on every falling edge.
// Ends with a single TB_RESULT summary line.
`timescale 1ns/1ps
module tb_reorder_rd_ctrl;

  localparam int AWA = 3;
  localparam int NA  = 8;
  localparam int AWB = 12;
  localparam int DGB = 4;
  localparam int NB  = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- instance A: AW=3, DIGIT=1 ----------------
  logic            wr_done_a, rd_en_a, out_valid_a, out_ready_a, out_last_a;
  logic            frame_done_a, busy_a, ovr_err_a;
  logic [AWA-1:0]  rd_addr_a;
  logic [31:0]     rd_data_a, out_data_a;

  reorder_rd_ctrl #(.AW(AWA), .DW(32), .DIGIT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .wr_done(wr_done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_last(out_last_a), .frame_done(frame_done_a), .busy(busy_a), .ovr_err(ovr_err_a)
  );

  // ---------------- instance B: AW=12, DIGIT=4 ----------------
  logic            wr_done_b, rd_en_b, out_valid_b, out_ready_b, out_last_b;
  logic            frame_done_b, busy_b, ovr_err_b;
  logic [AWB-1:0]  rd_addr_b;
  logic [31:0]     rd_data_b, out_data_b;

  reorder_rd_ctrl #(.AW(AWB), .DW(32), .DIGIT(DGB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr_done(wr_done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_last(out_last_b), .frame_done(frame_done_b), .busy(busy_b), .ovr_err(ovr_err_b)
  );

  // RAM models: data valid one cycle after the read strobe.
  logic [31:0] mem_a [NA];
  logic [31:0] mem_b [NB];
  always @(posedge clk) if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
  always @(posedge clk) if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference digit reversal: peel digits from the bottom, stack them from the top.
  function automatic int unsigned digrev(input int unsigned k, input int aw, input int d);
    int unsigned r;
    r = 0;
    for (int i = 0; i < aw / d; i++)
      r = r * (32'd1 << d) + ((k >> (i * d)) % (32'd1 << d));
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model A ----------------
  int   rd_k_a, beat_k_a, fd_cnt_a;
  bit   m_busy_a, m_ovr_a, m_fd_a, stall_a;
  logic [31:0] stall_dat_a;
  logic        stall_last_a;

  always @(negedge clk) begin : mon_a
    bit busy_n, fd_n, ovr_n;
    if (!rst_n) begin
      rd_k_a = 0; beat_k_a = 0; m_busy_a = 0; m_ovr_a = 0; m_fd_a = 0; stall_a = 0;
    end else begin
      busy_n = m_busy_a; fd_n = 0; ovr_n = m_ovr_a;
      chk("a_busy", busy_a, m_busy_a);
      chk("a_ovr_err", ovr_err_a, m_ovr_a);
      chk("a_frame_done", frame_done_a, m_fd_a);
      if (stall_a) begin
        chk("a_hold_valid", out_valid_a, 1'b1);
        chk("a_hold_data", out_data_a, stall_dat_a);
        chk("a_hold_last", out_last_a, stall_last_a);
      end
      if (rd_en_a) begin
        chk("a_rd_in_frame", m_busy_a && (rd_k_a < NA), 1'b1);
        chk("a_rd_addr", rd_addr_a, digrev(rd_k_a, AWA, 1));
        rd_k_a++;
      end
      if (out_valid_a && out_ready_a) begin
        chk("a_beat_in_frame", m_busy_a, 1'b1);
        chk("a_beat_data", out_data_a, mem_a[digrev(beat_k_a, AWA, 1) % NA]);
        chk("a_beat_last", out_last_a, beat_k_a == NA - 1);
        beat_k_a++;
        if (beat_k_a == NA) begin
          busy_n = 0; fd_n = 1; fd_cnt_a++;
          chk("a_all_read", rd_k_a, NA);
        end
      end
      chk("a_outstanding_le2", (rd_k_a - beat_k_a) <= 2, 1'b1);
      if (wr_done_a) begin
        if (m_busy_a) ovr_n = 1;
        else begin busy_n = 1; rd_k_a = 0; beat_k_a = 0; end
      end
      stall_a = out_valid_a && !out_ready_a;
      stall_dat_a = out_data_a;
      stall_last_a = out_last_a;
      m_busy_a = busy_n; m_fd_a = fd_n; m_ovr_a = ovr_n;
    end
  end

  // ---------------- reference model B ----------------
  int rd_k_b, beat_k_b, fd_cnt_b;
  int seen_b [NB];

  always @(negedge clk) begin : mon_b
    if (!rst_n) begin
      rd_k_b = 0; beat_k_b = 0;
    end else begin
      if (rd_en_b) begin
        chk("b_rd_addr", rd_addr_b, digrev(rd_k_b, AWB, DGB));
        if (rd_k_b == 'h123) chk("b_rev_0x123", rd_addr_b, 12'h321);
        if (rd_k_b == 'h00F) chk("b_rev_0x00f", rd_addr_b, 12'hF00);
        seen_b[rd_addr_b]++;
        rd_k_b++;
      end
      if (out_valid_b && out_ready_b) begin
        chk("b_beat_data", out_data_b, mem_b[digrev(beat_k_b, AWB, DGB) % NB]);
        chk("b_beat_last", out_last_b, beat_k_b == NB - 1);
        beat_k_b++;
        if (beat_k_b == NB) fd_cnt_b++;
      end
      chk("b_outstanding_le2", (rd_k_b - beat_k_b) <= 2, 1'b1);
    end
  end

  // Poll until the model has seen the last beat of the current frame (ends in the frame_done cycle).
  task automatic wait_last_a(input int start, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (fd_cnt_a != start) break;
      cyc();
    end
    chk("a_frame_complete", fd_cnt_a, start + 1);
  endtask

  task automatic start_a();
    wr_done_a = 1'b1;
    cyc();
    wr_done_a = 1'b0;
  endtask

  task automatic t_basic();
    int ea [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    out_ready_a = 1'b1;
    start_a();
    for (int t = 1; t <= 11; t++) begin
      @(negedge clk);
      chk("basic_rd_en", rd_en_a, (t <= 8));
      if (t <= 8) chk("basic_rd_addr", rd_addr_a, ea[t-1]);
      chk("basic_valid", out_valid_a, (t >= 3 && t <= 10));
      if (t >= 3 && t <= 10) chk("basic_data", out_data_a, 100 + ea[t-3]);
      chk("basic_last", out_last_a, (t == 10));
      chk("basic_frame_done", frame_done_a, (t == 11));
      chk("basic_busy", busy_a, (t <= 10));
      cyc();
    end
  endtask

  task automatic t_backpressure();
    int start = fd_cnt_a;
    out_ready_a = 1'b1;
    start_a();
    for (int i = 0; i < 50; i++) begin
      if (beat_k_a >= 3) break;
      cyc();
    end
    chk("bp_third_beat", beat_k_a, 3);
    out_ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rd_en_low", rd_en_a, 1'b0);
      chk("bp_valid_held", out_valid_a, 1'b1);
      cyc();
    end
    out_ready_a = 1'b1;
    wait_last_a(start, 50);
    cyc();
  endtask

  task automatic t_overrun();
    int start = fd_cnt_a;
    out_ready_a = 1'b1;
    start_a();
    for (int i = 0; i < 50; i++) begin
      if (rd_k_a == 3) break;
      cyc();
    end
    wr_done_a = 1'b1;
    cyc();
    wr_done_a = 1'b0;
    @(negedge clk);
    chk("ovr_set", ovr_err_a, 1'b1);
    wait_last_a(start, 50);
    cyc();
    chk("ovr_sticky", ovr_err_a, 1'b1);
  endtask

  task automatic t_reset_mid();
    int start;
    start_a();
    for (int i = 0; i < 200; i++) begin
      if (beat_k_a >= 5) break;
      out_ready_a = ($urandom_range(0, 3) != 0);
      cyc();
    end
    chk("rst_reached_beat5", beat_k_a, 5);
    rst_n = 1'b0;
    #1;
    chk("rst_rd_en", rd_en_a, 1'b0);
    chk("rst_rd_addr", rd_addr_a, 0);
    chk("rst_out_valid", out_valid_a, 1'b0);
    chk("rst_out_last", out_last_a, 1'b0);
    chk("rst_out_data", out_data_a, 0);
    chk("rst_frame_done", frame_done_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_ovr_err", ovr_err_a, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc();
    out_ready_a = 1'b1;
    start = fd_cnt_a;
    start_a();
    @(negedge clk);
    chk("rst_restart_rd_en", rd_en_a, 1'b1);
    chk("rst_restart_addr", rd_addr_a, 0);
    cyc();
    wait_last_a(start, 50);
    cyc();
  endtask

  task automatic t_back_to_back();
    int start = fd_cnt_a;
    out_ready_a = 1'b1;
    start_a();
    wait_last_a(start, 50);
    start = fd_cnt_a;
    wr_done_a = 1'b1;
    @(negedge clk);
    chk("b2b_frame_done", frame_done_a, 1'b1);
    cyc();
    wr_done_a = 1'b0;
    @(negedge clk);
    chk("b2b_rd_en", rd_en_a, 1'b1);
    chk("b2b_rd_addr", rd_addr_a, 0);
    cyc();
    wait_last_a(start, 50);
    cyc();
    chk("b2b_ovr_clear", ovr_err_a, 1'b0);
  endtask

  task automatic t_random();
    for (int f = 0; f < 6; f++) begin
      int start = fd_cnt_a;
      out_ready_a = ($urandom_range(0, 1) != 0);
      start_a();
      for (int i = 0; i < 300; i++) begin
        if (fd_cnt_a != start) break;
        out_ready_a = ($urandom_range(0, 3) != 0);
        wr_done_a = (f >= 3) && m_busy_a && ($urandom_range(0, 15) == 0);
        cyc();
      end
      wr_done_a = 1'b0;
      chk("rand_frame_complete", fd_cnt_a, start + 1);
      cyc();
    end
  endtask

  task automatic t_radix16();
    int start = fd_cnt_b;
    int bad = 0;
    wr_done_b = 1'b1;
    cyc();
    wr_done_b = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (fd_cnt_b != start) break;
      out_ready_b = ($urandom_range(0, 3) != 0);
      cyc();
    end
    cyc();
    cyc();
    chk("b_frame_complete", fd_cnt_b, start + 1);
    chk("b_beat_count", beat_k_b, NB);
    for (int a = 0; a < NB; a++) if (seen_b[a] != 1) bad++;
    chk("b_each_addr_once", bad, 0);
    chk("b_ovr_err", ovr_err_b, 1'b0);
    chk("b_idle_after", busy_b, 1'b0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < NA; a++) mem_a[a] = 32'(a + 100);
    for (int a = 0; a < NB; a++) begin mem_b[a] = $urandom; seen_b[a] = 0; end
    rst_n = 1'b0;
    wr_done_a = 1'b0; out_ready_a = 1'b0;
    wr_done_b = 1'b0; out_ready_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_rd_en", rd_en_a, 1'b0);
    chk("init_rd_addr", rd_addr_a, 0);
    chk("init_out_valid", out_valid_a, 1'b0);
    chk("init_out_data", out_data_a, 0);
    chk("init_busy", busy_a, 1'b0);
    chk("init_frame_done", frame_done_a, 1'b0);
    rst_n = 1'b1;
    cyc();
    cyc();
    t_basic();
    cyc();
    t_backpressure();
    t_overrun();
    t_reset_mid();
    t_back_to_back();
    t_random();
    t_radix16();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
